// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline-stage register with a 2-entry skid buffer, NOP bubble on flush/empty.
// Optional stall counter enabled by defining ELASTIC_PIPE_STALL_CNT_EN.
module elastic_pipe_reg #(
  parameter int unsigned              DATA_W   = 16,
  parameter logic [DATA_W-1:0]        NOP_DATA = 16'h1000,
  parameter int unsigned              CTRL_W   = 8,
  parameter logic [CTRL_W-1:0]        NOP_CTRL = '0,
  parameter int unsigned              CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_count
);

  // Encoding equals the number of held beats, so occupancy doubles as the state debug view.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic              accept, drain;

  // Handshake: a beat moves on a rising edge where valid and ready are both high;
  // in_ready depends only on registered state, flush and rst, never on out_ready.
  assign in_ready  = (state_q != FULL) && !flush && !rst;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;
  assign occupancy = state_q;
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      state_d     = EMPTY;
      main_data_d = NOP_DATA;
      main_ctrl_d = NOP_CTRL;
      skid_data_d = NOP_DATA;
      skid_ctrl_d = NOP_CTRL;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d     = ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end
        ONE: begin
          if (accept && !drain) begin
            state_d     = FULL;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else if (accept && drain) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (drain) begin
            state_d     = EMPTY;
            main_data_d = NOP_DATA;
            main_ctrl_d = NOP_CTRL;
          end
        end
        FULL: begin
          if (drain) begin
            state_d     = ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            skid_data_d = NOP_DATA;
            skid_ctrl_d = NOP_CTRL;
          end
        end
        default: begin
          state_d     = EMPTY;
          main_data_d = NOP_DATA;
          main_ctrl_d = NOP_CTRL;
          skid_data_d = NOP_DATA;
          skid_ctrl_d = NOP_CTRL;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_data_q <= NOP_DATA;
      main_ctrl_q <= NOP_CTRL;
      skid_data_q <= NOP_DATA;
      skid_ctrl_q <= NOP_CTRL;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

`ifdef ELASTIC_PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q;

  // Saturating; flush deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule
